// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_schedule
//  Description : DES round-key generator. Produces K1..K16 (or K16..K1 for
//                decrypt) one subkey per valid/ready handshake from a 64-bit
//                key via PC-1, per-round C/D rotation and PC-2.
//  Revision    : 1.0  initial release
// ============================================================================
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // PC-1: FIPS key bit numbers (1 = key[63]) for output bits 1..56.
    localparam logic [6:0] PC1_TAB [0:55] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    // PC-2: {C,D} bit numbers (1 = C[27]) for subkey bits 1..48.
    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;

    logic [55:0] pc1_cd;
    logic [55:0] cd_cur;
    logic [4:0]  enc_idx;
    logic [4:0]  dec_idx;

    // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
    function automatic logic single_shift(input logic [4:0] idx);
        return (idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic one);
        return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    // PC-1 selection of the raw key; parity bits fall out naturally.
    always_comb begin
        pc1_cd = '0;
        for (int j = 0; j < 56; j++) begin
            pc1_cd[55 - j] = key[6'(7'd64 - PC1_TAB[j])];
        end
    end

    // PC-2 of the registered halves; subkey follows state with no extra latency.
    always_comb begin
        cd_cur = {c_q, d_q};
        subkey = '0;
        for (int j = 0; j < 48; j++) begin
            subkey[47 - j] = cd_cur[6'(6'd56 - PC2_TAB[j])];
        end
    end

    // Shift index of the round that follows (encrypt) or precedes (decrypt).
    assign enc_idx = {1'b0, round_q} + 5'd2;
    assign dec_idx = {1'b0, round_q} + 5'd1;

    // Next-state: load on start, step C/D on each accepted subkey.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        count_d = count_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = decrypt;
                    count_d = 4'd0;
                    state_d = ST_RUN;
                    if (decrypt) begin
                        // C16/D16 equal C0/D0 after the full 28-position wrap.
                        c_d     = pc1_cd[55:28];
                        d_d     = pc1_cd[27:0];
                        round_d = 4'd15;
                    end else begin
                        c_d     = rotl(pc1_cd[55:28], 1'b1);
                        d_d     = rotl(pc1_cd[27:0], 1'b1);
                        round_d = 4'd0;
                    end
                end
            end
            ST_RUN: begin
                if (subkey_ready) begin
                    if (count_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + 4'd1;
                        if (mode_q) begin
                            c_d     = rotr(c_q, single_shift(dec_idx));
                            d_d     = rotr(d_q, single_shift(dec_idx));
                            round_d = round_q - 4'd1;
                        end else begin
                            c_d     = rotl(c_q, single_shift(enc_idx));
                            d_d     = rotl(d_q, single_shift(enc_idx));
                            round_d = round_q + 4'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            count_q <= count_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    assign subkey_valid = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign round        = round_q;

endmodule
`default_nettype wire
